// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and counter width shared by the sync generator.
// The derived totals and sync windows are for the default mode only.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Clock divider producing a registered one-clk pixel enable every CLK_DIV clocks.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_tick;

  // The tick is registered from the terminal count, so after release the
  // first enable appears on the CLK_DIV-th edge with reset high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_LAST);
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
  end

  assign p_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters plus hsync, vsync, video_on and
// frame_start, all registered from next-state counter values.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) || CLK_DIV < 1) begin : g_bad_params
    $error("vga_sync_gen: timing totals exceed the counter range or CLK_DIV < 1");
  end

  logic             w_tick;
  logic             w_x_end;
  logic             w_y_end;
  logic             w_wrap;
  logic [CNT_W-1:0] w_next_x;
  logic [CNT_W-1:0] w_next_y;

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hs;
  logic             r_vs;
  logic             r_von;
  logic             r_fs;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (w_tick)
  );

  always_comb begin
    w_x_end  = (r_x == H_LAST);
    w_y_end  = (r_y == V_LAST);
    w_wrap   = 1'b0;
    w_next_x = r_x;
    w_next_y = r_y;
    if (w_tick) begin
      w_next_x = w_x_end ? '0 : r_x + CNT_W'(1);
      if (w_x_end) begin
        w_next_y = w_y_end ? '0 : r_y + CNT_W'(1);
        w_wrap   = w_y_end;
      end
    end
  end

  // Decoding the next-state counters keeps sync/blank aligned with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_von <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_x   <= w_next_x;
      r_y   <= w_next_y;
      r_hs  <= !in_window(w_next_x, HS_START, HS_END);
      r_vs  <= !in_window(w_next_y, VS_START, VS_END);
      r_von <= (w_next_x < H_VIS) && (w_next_y < V_VIS);
      r_fs  <= w_wrap;
    end
  end

  assign p_tick      = w_tick;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign video_on    = r_von;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for line timing and a shrunken
// instance so whole frames fit in a short run, both against an arithmetic model.
module tb_vga_sync_gen;

  localparam int LD = 4, LHD = 640, LHF = 16, LHS = 96, LHB = 48;
  localparam int LVD = 480, LVF = 10, LVS = 2, LVB = 33;
  localparam int SD = 3, SHD = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVD = 6, SVF = 2, SVS = 2, SVB = 3;
  localparam int S_FRAME_CLKS = SD * (SHD + SHF + SHS + SHB) * (SVD + SVF + SVS + SVB);

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       l_p_tick, l_hsync, l_vsync, l_video_on, l_frame_start;
  logic [9:0] l_pixel_x, l_pixel_y;
  logic       s_p_tick, s_hsync, s_vsync, s_video_on, s_frame_start;
  logic [9:0] s_pixel_x, s_pixel_y;

  int checks = 0;
  int errors = 0;
  int k = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk (clk), .reset (reset), .p_tick (l_p_tick),
    .pixel_x (l_pixel_x), .pixel_y (l_pixel_y), .hsync (l_hsync), .vsync (l_vsync),
    .video_on (l_video_on), .frame_start (l_frame_start)
  );

  vga_sync_gen #(
    .CLK_DIV (SD), .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_DISPLAY (SVD), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
  ) dut_s (
    .clk (clk), .reset (reset), .p_tick (s_p_tick),
    .pixel_x (s_pixel_x), .pixel_y (s_pixel_y), .hsync (s_hsync), .vsync (s_vsync),
    .video_on (s_video_on), .frame_start (s_frame_start)
  );

  // Expected outputs k edges after the first edge with reset high: every
  // CLK_DIV clocks one tick, each tick advances one raster position.
  function automatic logic [24:0] model(input int kk, input bit rst_on, input int d,
                                        input int hd, input int hf, input int hs, input int hb,
                                        input int vd, input int vf, input int vs, input int vb);
    int ht, vt, pos, x, y;
    logic tick, hsn, vsn, von, fs;
    if (rst_on) return {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    ht   = hd + hf + hs + hb;
    vt   = vd + vf + vs + vb;
    pos  = (kk / d) % (ht * vt);
    x    = pos % ht;
    y    = pos / ht;
    tick = ((kk % d) == d - 1);
    hsn  = !((x >= hd + hf) && (x < hd + hf + hs));
    vsn  = !((y >= vd + vf) && (y < vd + vf + vs));
    von  = (x < hd) && (y < vd);
    fs   = (kk > 0) && ((kk % d) == 0) && (pos == 0);
    return {tick, 10'(x), 10'(y), hsn, vsn, von, fs};
  endfunction

  task automatic check_both(input int kk, input bit rst_on, input string tag);
    logic [24:0] exp_l, exp_s, obs_l, obs_s;
    exp_l = model(kk, rst_on, LD, LHD, LHF, LHS, LHB, LVD, LVF, LVS, LVB);
    exp_s = model(kk, rst_on, SD, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB);
    obs_l = {l_p_tick, l_pixel_x, l_pixel_y, l_hsync, l_vsync, l_video_on, l_frame_start};
    obs_s = {s_p_tick, s_pixel_x, s_pixel_y, s_hsync, s_vsync, s_video_on, s_frame_start};
    checks++;
    assert (obs_l === exp_l) else begin
      errors++;
      $error("FAIL %s_full k=%0d observed=%h expected=%h (tick,x,y,hs,vs,von,fs)", tag, kk, obs_l, exp_l);
    end
    checks++;
    assert (obs_s === exp_s) else begin
      errors++;
      $error("FAIL %s_small k=%0d observed=%h expected=%h (tick,x,y,hs,vs,von,fs)", tag, kk, obs_s, exp_s);
    end
  endtask

  initial begin
    int first_tick, hs_low_clks, hs_low_ticks, von_ticks, vs_low_ticks;
    int last_fs, fs_count, n, r;
    bit found;

    // Reset held low for 10 clocks.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_both(0, 1'b1, "reset_hold");
    end

    // Release and run a little over one full-size line (several small frames).
    reset = 1'b1;
    k = -1;
    first_tick = -1; hs_low_clks = 0; hs_low_ticks = 0;
    von_ticks = 0; vs_low_ticks = 0; last_fs = -1; fs_count = 0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      k++;
      check_both(k, 1'b0, "run");
      if (l_p_tick && first_tick < 0) first_tick = k;
      if (k < LD * 800) begin
        if (!l_hsync) hs_low_clks++;
        if (!l_hsync && l_p_tick) hs_low_ticks++;
      end
      if (k >= S_FRAME_CLKS && k < 2 * S_FRAME_CLKS) begin
        if (s_p_tick && s_video_on) von_ticks++;
        if (s_p_tick && !s_vsync) vs_low_ticks++;
      end
      if (s_frame_start) begin
        if (last_fs >= 0) begin
          checks++;
          assert (k - last_fs === S_FRAME_CLKS) else begin
            errors++;
            $error("FAIL frame_gap observed=%0d expected=%0d", k - last_fs, S_FRAME_CLKS);
          end
        end
        last_fs = k;
        fs_count++;
      end
    end
    checks++;
    assert (first_tick === LD - 1) else begin
      errors++;
      $error("FAIL first_tick_edge observed=%0d expected=%0d", first_tick, LD - 1);
    end
    checks++;
    assert (hs_low_clks === LHS * LD) else begin
      errors++;
      $error("FAIL hsync_low_clks observed=%0d expected=%0d", hs_low_clks, LHS * LD);
    end
    checks++;
    assert (hs_low_ticks === LHS) else begin
      errors++;
      $error("FAIL hsync_low_ticks observed=%0d expected=%0d", hs_low_ticks, LHS);
    end
    checks++;
    assert (von_ticks === SHD * SVD) else begin
      errors++;
      $error("FAIL video_on_ticks observed=%0d expected=%0d", von_ticks, SHD * SVD);
    end
    checks++;
    assert (vs_low_ticks === SVS * (SHD + SHF + SHS + SHB)) else begin
      errors++;
      $error("FAIL vsync_low_ticks observed=%0d expected=%0d", vs_low_ticks, SVS * (SHD + SHF + SHS + SHB));
    end
    checks++;
    assert (fs_count === 3299 / S_FRAME_CLKS) else begin
      errors++;
      $error("FAIL frame_start_count observed=%0d expected=%0d", fs_count, 3299 / S_FRAME_CLKS);
    end

    // Resets at random divider/counter phases, then restart from (0,0).
    for (int rep = 0; rep < 3; rep++) begin
      n = $urandom_range(50, 900);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        k++;
        check_both(k, 1'b0, "pre_reset");
      end
      reset = 1'b0;
      r = $urandom_range(1, 4);
      for (int i = 0; i < r; i++) begin
        @(negedge clk);
        check_both(0, 1'b1, "mid_reset");
      end
      reset = 1'b1;
      k = -1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        k++;
        check_both(k, 1'b0, "post_reset");
      end
    end

    // Reset while the small instance is in both hsync and vsync pulses.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      k++;
      check_both(k, 1'b0, "seek_sync");
      if (!s_hsync && !s_vsync) found = 1'b1;
    end
    checks++;
    assert (found === 1'b1) else begin
      errors++;
      $error("FAIL sync_window_reached observed=%0b expected=1", found);
    end
    reset = 1'b0;
    @(negedge clk);
    check_both(0, 1'b1, "sync_reset");
    reset = 1'b1;
    k = -1;
    for (int i = 0; i < S_FRAME_CLKS + 20; i++) begin
      @(negedge clk);
      k++;
      check_both(k, 1'b0, "after_sync_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
